// File: rtl/remote_cmd_sched.sv
// Remote-side command scheduler: queues {cmd,data} requests, launches them to RemoteComm one at a
// time, checks each response against ACK and retries on NAK/timeout before retiring the entry.
module remote_cmd_sched #(
    parameter int         DEPTH     = 4,
    parameter int         TMO_CYC   = 200000,
    parameter int         MAX_RETRY = 2,
    parameter logic [7:0] ACK       = 8'hA5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cq_wr,
    input  logic [7:0]  cq_cmd,
    input  logic [15:0] cq_data,
    output logic        q_full,
    output logic        q_empty,
    output logic        send_cmd,
    output logic [7:0]  cmd,
    output logic [15:0] data,
    input  logic        cmd_sent,
    input  logic        resp_rdy,
    input  logic [7:0]  resp,
    output logic        clr_resp_rdy,
    output logic        busy,
    output logic        done,
    output logic        done_ok,
    output logic        err,
    output logic [7:0]  err_cmd,
    input  logic        clr_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TMO_CYC + 1);
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [AW:0]   CNT_FULL   = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE    = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TMO_CYC - 1);
    localparam logic [TW-1:0] TMO_SAT    = {TW{1'b1}};
    localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LAUNCH = 3'd1,
        TX     = 3'd2,
        RESP   = 3'd3,
        EVAL   = 3'd4
    } state_t;

    logic [7:0]    cmd_mem_r  [DEPTH];
    logic [15:0]   data_mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic [AW:0]   count_nxt_s;
    logic          q_full_r;
    logic          q_empty_r;
    logic          push_s;
    logic          pop_s;
    logic          success_s;

    state_t        state_r;
    logic [RW-1:0] retry_cnt_r;
    logic [TW-1:0] tmo_cnt_r;
    logic          timeout_r;
    logic [7:0]    resp_r;
    logic          send_cmd_r;
    logic          clr_resp_rdy_r;
    logic          busy_r;
    logic          done_r;
    logic          done_ok_r;
    logic          err_r;
    logic [7:0]    err_cmd_r;

    assign q_full       = q_full_r;
    assign q_empty      = q_empty_r;
    assign cmd          = cmd_mem_r[rd_ptr_r];
    assign data         = data_mem_r[rd_ptr_r];
    assign send_cmd     = send_cmd_r;
    assign clr_resp_rdy = clr_resp_rdy_r;
    assign busy         = busy_r;
    assign done         = done_r;
    assign done_ok      = done_ok_r;
    assign err          = err_r;
    assign err_cmd      = err_cmd_r;

    // Push/pop decisions and next occupancy; a full queue rejects writes even when popping.
    always_comb begin
        push_s    = cq_wr && !q_full_r;
        success_s = !timeout_r && (resp_r == ACK);
        if (state_r == EVAL) begin
            pop_s = success_s || (retry_cnt_r == RETRY_LAST);
        end else begin
            pop_s = 1'b0;
        end
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase
    end

    // Request FIFO storage, pointers and registered full/empty flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r  <= '0;
            rd_ptr_r  <= '0;
            count_r   <= '0;
            q_full_r  <= 1'b0;
            q_empty_r <= 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                cmd_mem_r[i]  <= 8'h00;
                data_mem_r[i] <= 16'h0000;
            end
        end else begin
            if (push_s) begin
                cmd_mem_r[wr_ptr_r]  <= cq_cmd;
                data_mem_r[wr_ptr_r] <= cq_data;
                wr_ptr_r             <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r   <= count_nxt_s;
            q_full_r  <= (count_nxt_s == CNT_FULL);
            q_empty_r <= (count_nxt_s == '0);
        end
    end

    // Transaction FSM with registered handshake and status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r        <= IDLE;
            retry_cnt_r    <= '0;
            tmo_cnt_r      <= '0;
            timeout_r      <= 1'b0;
            resp_r         <= 8'h00;
            send_cmd_r     <= 1'b0;
            clr_resp_rdy_r <= 1'b0;
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
            done_ok_r      <= 1'b0;
            err_r          <= 1'b0;
            err_cmd_r      <= 8'h00;
        end else begin
            send_cmd_r     <= 1'b0;
            clr_resp_rdy_r <= 1'b0;
            done_r         <= 1'b0;
            // A failing retirement below overrides this clear in the same cycle.
            if (clr_err) begin
                err_r <= 1'b0;
            end
            case (state_r)
                IDLE: begin
                    if (!q_empty_r) begin
                        state_r    <= LAUNCH;
                        send_cmd_r <= 1'b1;
                        busy_r     <= 1'b1;
                    end
                end
                LAUNCH: begin
                    tmo_cnt_r <= '0;
                    state_r   <= TX;
                end
                TX: begin
                    if (cmd_sent) begin
                        tmo_cnt_r <= '0;
                        state_r   <= RESP;
                    end
                end
                RESP: begin
                    if (tmo_cnt_r != TMO_SAT) begin
                        tmo_cnt_r <= tmo_cnt_r + TW'(1);
                    end
                    if (resp_rdy) begin
                        clr_resp_rdy_r <= 1'b1;
                        resp_r         <= resp;
                        timeout_r      <= 1'b0;
                        state_r        <= EVAL;
                    end else if (tmo_cnt_r == TMO_LAST) begin
                        timeout_r <= 1'b1;
                        state_r   <= EVAL;
                    end
                end
                EVAL: begin
                    if (success_s) begin
                        done_r      <= 1'b1;
                        done_ok_r   <= 1'b1;
                        retry_cnt_r <= '0;
                        busy_r      <= 1'b0;
                        state_r     <= IDLE;
                    end else if (retry_cnt_r < RETRY_LAST) begin
                        retry_cnt_r <= retry_cnt_r + RW'(1);
                        send_cmd_r  <= 1'b1;
                        state_r     <= LAUNCH;
                    end else begin
                        done_r      <= 1'b1;
                        done_ok_r   <= 1'b0;
                        err_r       <= 1'b1;
                        err_cmd_r   <= cmd_mem_r[rd_ptr_r];
                        retry_cnt_r <= '0;
                        busy_r      <= 1'b0;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_remote_cmd_sched.sv
// Bench for remote_cmd_sched: a RemoteComm responder plus a transaction-level reference model
// (request queue, attempt counting, sticky error) checked every cycle at the falling edge.
module tb_remote_cmd_sched;
    localparam int         DEPTH = 4;
    localparam int         TMO   = 64;
    localparam int         MAXR  = 2;
    localparam logic [7:0] ACK   = 8'hA5;

    logic        clk, rst_n, cq_wr, q_full, q_empty, send_cmd, cmd_sent, resp_rdy;
    logic        clr_resp_rdy, busy, done, done_ok, err, clr_err;
    logic [7:0]  cq_cmd, cmd, resp, err_cmd;
    logic [15:0] cq_data, data;

    remote_cmd_sched #(.DEPTH(DEPTH), .TMO_CYC(TMO), .MAX_RETRY(MAXR), .ACK(ACK)) dut (
        .clk(clk), .rst_n(rst_n), .cq_wr(cq_wr), .cq_cmd(cq_cmd), .cq_data(cq_data),
        .q_full(q_full), .q_empty(q_empty), .send_cmd(send_cmd), .cmd(cmd), .data(data),
        .cmd_sent(cmd_sent), .resp_rdy(resp_rdy), .resp(resp), .clr_resp_rdy(clr_resp_rdy),
        .busy(busy), .done(done), .done_ok(done_ok), .err(err), .err_cmd(err_cmd),
        .clr_err(clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0, errors = 0, cyc = 0;
    logic [23:0] mq[$];
    int attempts = 0, launches = 0, dones = 0, resp_given = 0, clr_pulses = 0;
    bit last_ok = 1'b0, m_err = 1'b0, clr_pending = 1'b0;
    logic [7:0] m_err_cmd = 8'h00;
    int tx_wait = 0, resp_wait = 0, t_sent = 0, exp_gap = 0, pend_lat = 1;
    bit gap_armed = 1'b0, pend_resp = 1'b0;
    logic [7:0] pend_byte = 8'h00;
    // responder policy: random, or first pol_bad attempts fail (by timeout if pol_tmo)
    bit pol_rand = 1'b0, pol_tmo = 1'b0;
    int pol_bad = 0, pol_lat = 3;

    typedef struct {
        logic [7:0]  cmd;
        logic [15:0] data;
        logic [1:0]  bad;
        logic        tmo;
        logic [7:0]  lat;
        logic        exp_ok;
        logic [1:0]  exp_sends;
        logic        exp_err;
        logic [7:0]  exp_err_cmd;
    } vec_t;
    vec_t vt[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        logic [7:0] bad_b;
        int kind, r2;
        @(negedge clk);
        cyc++;
        cq_wr   = 1'b0;
        clr_err = 1'b0;
        if (clr_pending) begin
            m_err       = 1'b0;
            clr_pending = 1'b0;
        end
        if (mq.size() == 0) begin
            chk("done_unexpected", done, 1'b0);
        end else if (done) begin
            dones++;
            if (gap_armed) begin
                chk("attempt_gap", cyc - t_sent, exp_gap);
                gap_armed = 1'b0;
            end
            chk("done_ok", done_ok, last_ok);
            if (!last_ok) begin
                chk("fail_attempts", attempts, MAXR + 1);
                m_err     = 1'b1;
                m_err_cmd = mq[0][23:16];
            end
            void'(mq.pop_front());
            attempts = 0;
        end
        chk("q_empty", q_empty, (mq.size() == 0));
        chk("q_full", q_full, (mq.size() == DEPTH));
        chk("err", err, m_err);
        chk("err_cmd", err_cmd, m_err_cmd);
        // RemoteComm responder
        cmd_sent = 1'b0;
        if (clr_resp_rdy) begin
            clr_pulses++;
            chk("clr_with_resp", resp_rdy, 1'b1);
            resp_rdy = 1'b0;
        end
        if (send_cmd) begin
            launches++;
            if (gap_armed) begin
                chk("attempt_gap", cyc - t_sent, exp_gap);
                gap_armed = 1'b0;
            end
            if (mq.size() == 0) begin
                chk("launch_unexpected", send_cmd, 1'b0);
            end else begin
                if (attempts > 0) chk("retry_after_ok", last_ok, 1'b0);
                chk("launch_cmd", cmd, mq[0][23:16]);
                chk("launch_data", data, mq[0][15:0]);
                attempts++;
                chk("attempt_limit", (attempts <= MAXR + 1), 1'b1);
            end
            if (pol_rand) begin
                kind  = $urandom_range(0, 9);
                r2    = $urandom_range(0, 7);
                bad_b = 8'($urandom);
                if (bad_b == ACK) bad_b = 8'h5A;
                pend_lat  = (r2 < 6) ? r2 + 1 : ((r2 == 6) ? TMO - 1 : TMO);
                pend_resp = (kind < 8);
                pend_byte = (kind < 5) ? ACK : bad_b;
            end else begin
                pend_lat  = pol_lat;
                pend_resp = !((attempts <= pol_bad) && pol_tmo);
                pend_byte = (attempts <= pol_bad) ? 8'hFF : ACK;
            end
            last_ok = pend_resp && (pend_byte == ACK);
            exp_gap = (pend_resp ? pend_lat : TMO) + 2;
            tx_wait = $urandom_range(1, 3);
        end else if (tx_wait > 0) begin
            tx_wait--;
            if (tx_wait == 0) begin
                cmd_sent  = 1'b1;
                resp_wait = pend_lat;
                t_sent    = cyc;
                gap_armed = 1'b1;
            end
        end else if (resp_wait > 0) begin
            resp_wait--;
            if (resp_wait == 0 && pend_resp) begin
                resp_rdy = 1'b1;
                resp     = pend_byte;
                resp_given++;
            end
        end
    endtask

    task automatic enq(input logic [7:0] c, input logic [15:0] d);
        cq_wr   = 1'b1;
        cq_cmd  = c;
        cq_data = d;
        if (mq.size() < DEPTH) mq.push_back({c, d});
        tick();
    endtask

    task automatic wait_done(input int target, input int budget);
        int n = 0;
        while (dones < target && n < budget) begin
            tick();
            n++;
        end
        chk("done_wait_expired", (dones >= target), 1'b1);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        mq.delete();
        attempts = 0; last_ok = 1'b0; m_err = 1'b0; m_err_cmd = 8'h00; clr_pending = 1'b0;
        tx_wait = 0; resp_wait = 0; gap_armed = 1'b0; cmd_sent = 1'b0; resp_rdy = 1'b0;
        tick();
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_send", send_cmd, 1'b0);
        rst_n = 1'b1;
    endtask

    initial begin
        int l0, d0, n;
        rst_n = 1'b0; cq_wr = 1'b0; cq_cmd = 8'h00; cq_data = 16'h0000;
        cmd_sent = 1'b0; resp_rdy = 1'b0; resp = 8'h00; clr_err = 1'b0;
        vt[0] = '{8'h03, 16'h1234, 2'd0, 1'b0, 8'd63, 1'b1, 2'd1, 1'b0, 8'h00};
        vt[1] = '{8'h05, 16'hBEEF, 2'd3, 1'b0, 8'd5,  1'b0, 2'd3, 1'b1, 8'h05};
        vt[2] = '{8'h06, 16'h0006, 2'd0, 1'b0, 8'd1,  1'b1, 2'd1, 1'b1, 8'h05};
        vt[3] = '{8'h07, 16'h0007, 2'd3, 1'b1, 8'd4,  1'b0, 2'd3, 1'b1, 8'h07};
        vt[4] = '{8'h08, 16'h0008, 2'd1, 1'b1, 8'd4,  1'b1, 2'd2, 1'b1, 8'h07};
        vt[5] = '{8'h09, 16'h0009, 2'd0, 1'b0, 8'd64, 1'b1, 2'd1, 1'b1, 8'h07};
        vt[6] = '{8'h0A, 16'h000A, 2'd2, 1'b0, 8'd2,  1'b1, 2'd3, 1'b1, 8'h07};

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_q_empty", q_empty, 1'b1);
        chk("rst_q_full", q_full, 1'b0);
        chk("rst_outputs", {send_cmd, clr_resp_rdy, busy, done, done_ok, err}, 6'd0);
        chk("rst_cmd_data", {cmd, data, err_cmd}, 32'd0);
        rst_n = 1'b1;

        // stray handshakes while idle are ignored
        cmd_sent = 1'b1; resp_rdy = 1'b1; resp = ACK;
        repeat (3) begin
            @(negedge clk);
            chk("stray_clr", clr_resp_rdy, 1'b0);
            chk("stray_busy", busy, 1'b0);
        end
        cmd_sent = 1'b0; resp_rdy = 1'b0;

        // single command, launch two cycles after the enqueue edge
        d0 = dones; l0 = launches;
        enq(8'h02, 16'h0001);
        chk("launch_early", send_cmd, 1'b0);
        tick();
        chk("launch_at_2", send_cmd, 1'b1);
        wait_done(d0 + 1, 200);
        chk("t1_sends", launches - l0, 1);
        chk("t1_ok", done_ok, 1'b1);

        // fill the FIFO; fifth write dropped
        d0 = dones; l0 = launches;
        for (int k = 0; k < 4; k++) enq(8'(8'h02 + k), 16'(16'h0100 + k));
        chk("t2_full", q_full, 1'b1);
        enq(8'h66, 16'h6666);
        wait_done(d0 + 4, 400);
        repeat (10) tick();
        chk("t2_dones", dones - d0, 4);
        chk("t2_sends", launches - l0, 4);

        // table of single-command scenarios: NAK, timeout, expiry-cycle response, retries
        for (int i = 0; i < 7; i++) begin
            pol_bad = vt[i].bad; pol_tmo = vt[i].tmo; pol_lat = vt[i].lat;
            d0 = dones; l0 = launches;
            enq(vt[i].cmd, vt[i].data);
            wait_done(d0 + 1, 600);
            chk("vec_sends", launches - l0, vt[i].exp_sends);
            chk("vec_ok", done_ok, vt[i].exp_ok);
            chk("vec_err", err, vt[i].exp_err);
            chk("vec_err_cmd", err_cmd, vt[i].exp_err_cmd);
        end
        clr_err = 1'b1; clr_pending = 1'b1;
        tick();
        chk("clr_err_done", err, 1'b0);
        chk("err_cmd_holds", err_cmd, 8'h07);

        // reset during RESP abandons the transaction
        pol_bad = 3; pol_tmo = 1'b1; pol_lat = 3;
        enq(8'h11, 16'h1111);
        repeat (12) tick();
        chk("pre_rst_busy", busy, 1'b1);
        apply_reset();
        pol_bad = 0; pol_tmo = 1'b0;
        d0 = dones;
        enq(8'h12, 16'h1212);
        wait_done(d0 + 1, 200);
        chk("post_rst_ok", done_ok, 1'b1);

        // randomized traffic against the model
        pol_rand = 1'b1;
        for (int c = 0; c < 2500; c++) begin
            if ($urandom_range(0, 99) < 25) begin
                enq(8'($urandom), 16'($urandom));
            end else if ($urandom_range(0, 99) < 3) begin
                clr_err = 1'b1; clr_pending = 1'b1;
                tick();
            end else begin
                tick();
            end
        end
        n = 0;
        while ((mq.size() != 0 || busy) && n < 3000) begin
            tick();
            n++;
        end
        chk("drain", (mq.size() == 0 && !busy), 1'b1);
        chk("clr_pulses", clr_pulses, resp_given);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end
endmodule
